// File: rtl/operand_bypass_buffer.sv
// Operand bypass buffer: keeps a short history of recent writebacks and
// forwards the youngest matching producer for two source operands.
module operand_bypass_buffer #(
    parameter int LEN     = 32,
    parameter int NB_ADDR = 5,
    parameter int DEPTH   = 3,
    localparam int SRC_W  = $clog2(DEPTH + 2)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic               i_wr_valid,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [LEN-1:0]     i_wr_data,
    input  logic [NB_ADDR-1:0] i_rs_addr,
    input  logic [NB_ADDR-1:0] i_rt_addr,
    input  logic [LEN-1:0]     i_rs_rf,
    input  logic [LEN-1:0]     i_rt_rf,
    output logic [LEN-1:0]     o_rs,
    output logic [LEN-1:0]     o_rt,
    output logic [SRC_W-1:0]   o_rs_src,
    output logic [SRC_W-1:0]   o_rt_src
);

    logic               hist_valid_r [DEPTH];
    logic [NB_ADDR-1:0] hist_addr_r  [DEPTH];
    logic [LEN-1:0]     hist_data_r  [DEPTH];

    logic [LEN-1:0]     rs_sel_s;
    logic [LEN-1:0]     rt_sel_s;
    logic [SRC_W-1:0]   rs_src_s;
    logic [SRC_W-1:0]   rt_src_s;

    // Operand selection: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        rs_sel_s = i_rs_rf;
        rs_src_s = {SRC_W{1'b0}};
        rt_sel_s = i_rt_rf;
        rt_src_s = {SRC_W{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hist_valid_r[k] && (hist_addr_r[k] == i_rs_addr)) begin
                rs_sel_s = hist_data_r[k];
                rs_src_s = SRC_W'(k + 2);
            end else begin
                rs_sel_s = rs_sel_s;
            end
            if (hist_valid_r[k] && (hist_addr_r[k] == i_rt_addr)) begin
                rt_sel_s = hist_data_r[k];
                rt_src_s = SRC_W'(k + 2);
            end else begin
                rt_sel_s = rt_sel_s;
            end
        end
        if (i_wr_valid && (i_wr_addr == i_rs_addr)) begin
            rs_sel_s = i_wr_data;
            rs_src_s = SRC_W'(1);
        end else begin
            rs_src_s = rs_src_s;
        end
        if (i_wr_valid && (i_wr_addr == i_rt_addr)) begin
            rt_sel_s = i_wr_data;
            rt_src_s = SRC_W'(1);
        end else begin
            rt_src_s = rt_src_s;
        end
        // Register zero is hard-wired, so it is never forwarded.
        if (i_rs_addr == {NB_ADDR{1'b0}}) begin
            rs_sel_s = i_rs_rf;
            rs_src_s = {SRC_W{1'b0}};
        end else begin
            rs_sel_s = rs_sel_s;
        end
        if (i_rt_addr == {NB_ADDR{1'b0}}) begin
            rt_sel_s = i_rt_rf;
            rt_src_s = {SRC_W{1'b0}};
        end else begin
            rt_sel_s = rt_sel_s;
        end
    end

    // History shift register and registered outputs; flush beats stall beats shift.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                hist_valid_r[k] <= 1'b0;
                hist_addr_r[k]  <= {NB_ADDR{1'b0}};
                hist_data_r[k]  <= {LEN{1'b0}};
            end
            o_rs     <= {LEN{1'b0}};
            o_rt     <= {LEN{1'b0}};
            o_rs_src <= {SRC_W{1'b0}};
            o_rt_src <= {SRC_W{1'b0}};
        end else if (i_flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                hist_valid_r[k] <= 1'b0;
            end
            o_rs     <= {LEN{1'b0}};
            o_rt     <= {LEN{1'b0}};
            o_rs_src <= {SRC_W{1'b0}};
            o_rt_src <= {SRC_W{1'b0}};
        end else if (!i_stall) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                hist_valid_r[k] <= hist_valid_r[k-1];
                hist_addr_r[k]  <= hist_addr_r[k-1];
                hist_data_r[k]  <= hist_data_r[k-1];
            end
            hist_valid_r[0] <= i_wr_valid && (i_wr_addr != {NB_ADDR{1'b0}});
            hist_addr_r[0]  <= i_wr_addr;
            hist_data_r[0]  <= i_wr_data;
            o_rs     <= rs_sel_s;
            o_rt     <= rt_sel_s;
            o_rs_src <= rs_src_s;
            o_rt_src <= rt_src_s;
        end
    end

endmodule

// File: doc/operand_bypass_buffer.md
Name: operand_bypass_buffer

Overview:
- Parametrised successor to the pipeline's fixed 3-to-1 forwarding mux.
- Keeps a DEPTH-entry history of recent register-file writebacks.
- For two source operands (rs, rt), selects the youngest matching producer, or the register-file value when no producer matches, and registers the result.
- Sits between ID and EX. Replaces the external forwarding selector plus mux pair, and adds stall/flush handling.

Parameters:
- LEN, 32, data width of operands and writeback data
- NB_ADDR, 5, register address width
- DEPTH, 3, number of history entries (>=1)
- SRC_W, $clog2(DEPTH+2), width of source-code outputs (derived, not overridden)

Ports:
- i_clk  in  1  clock, all state updates on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_stall  in  1  hold history and outputs
- i_flush  in  1  invalidate history and zero outputs
- i_wr_valid  in  1  writeback this cycle
- i_wr_addr  in  NB_ADDR  writeback destination register
- i_wr_data  in  LEN  writeback data
- i_rs_addr  in  NB_ADDR  source operand A register
- i_rt_addr  in  NB_ADDR  source operand B register
- i_rs_rf  in  LEN  register-file read value for rs
- i_rt_rf  in  LEN  register-file read value for rt
- o_rs  out  LEN  registered selected operand A
- o_rt  out  LEN  registered selected operand B
- o_rs_src  out  SRC_W  registered source code for A
- o_rt_src  out  SRC_W  registered source code for B

Behaviour:
- Clocking and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high. While reset is asserted:
  - all history valid bits = 0, addr = 0, data = 0
  - o_rs = o_rt = 0, o_rs_src = o_rt_src = 0
- History entry k = {valid, addr, data}. Entry 0 is youngest.
- Source code values:
  - 0 = register file
  - 1 = live writeback port (current cycle)
  - k+2 = history entry k
- Selection (combinational, per operand, same rule for rs and rt):
  - Address 0 never forwards: code 0, value = *_rf.
  - Otherwise priority is:
    - live port, if i_wr_valid and i_wr_addr == src addr
    - then entry 0, 1, ..., DEPTH-1, first entry with valid and addr == src addr
    - then register file
  - The youngest match always wins. Multiple matching entries are legal.
- Rising edge, i_flush = 1 (flush has priority over stall and write):
  - all valid bits cleared
  - o_rs, o_rt, o_rs_src, o_rt_src <= 0
  - the live write that cycle is discarded, not pushed
- Rising edge, i_flush = 0, i_stall = 1:
  - history and all outputs hold
  - the live write is NOT captured; the producer must hold it during the stall
- Rising edge, i_flush = 0, i_stall = 0:
  - shift: entry[k] <= entry[k-1] for k = DEPTH-1..1
  - entry[0] <= {i_wr_valid && i_wr_addr != 0, i_wr_addr, i_wr_data}
  - entry DEPTH-1 falls off
  - outputs <= selection results, computed from pre-edge history and inputs
- Latency: operand visible on o_rs/o_rt one cycle after addresses are presented. A write presented in cycle N:
  - is forwardable via the live port in cycle N
  - is forwardable from entry k in cycles N+1+k, counting unstalled edges only
- No arithmetic. Widths are exact; no truncation paths.
- Reset asserted mid-operation clears everything immediately; the first edge after deassertion behaves as the unstalled case.

Test Plan:
- Reset, then rs=3, rt=4, rs_rf=0x11, rt_rf=0x22, no writes, one edge -> o_rs=0x11, o_rt=0x22, both src=0.
- wr_valid=1, wr_addr=3, data=0xAAAA with rs=3 in the same cycle -> next edge o_rs=0xAAAA, o_rs_src=1. Next cycle with no write, rs=3 -> o_rs=0xAAAA, src=2.
- Writes to r5 with 0x1 then 0x2 on consecutive unstalled edges, then rs=rt=5 -> o_rs=o_rt=0x2, src=2 (youngest). After DEPTH+1 further idle unstalled edges -> src=0, value = rs_rf.
- Write to r0 (wr_addr=0, data=0xFFFF) with rs=0, rs_rf=0 -> o_rs=0, src=0 on that cycle and all later cycles.
- Stall for 3 cycles after a write to r7 (0x77), with changing rs/rt -> outputs frozen. History still holds r7 in entry 0 when the stall is released, and rs=7 gives src=2.
- Flush and stall together with wr_valid=1 to r9 (0x99) -> outputs 0, src 0. The following cycle rs=9 returns rs_rf (write discarded). Async reset pulse mid-cycle -> outputs 0 before the next edge.
